ioctl_rom_loader: RTL and testbench

- Consumer end of the hps_io download stream. Receives 16-bit WIDE ioctl words and writes them as little-endian bytes into the CPU ROM port of `system`.
- Drives `ioctl_wait` so that a stalling or byte-wide memory cannot drop data.
- Sits between hps_io and the ROM BRAM write port in the emu top level.

---
 rtl/mrlaggy_pkg.sv | 14 +
 rtl/ioctl_rom_loader.sv | 181 ++++++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mrlaggy_pkg.sv
// Shared types and constants for the hps_io ROM download path.
package mrlaggy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    localparam int unsigned IOCTL_AW  = 27;
    localparam int unsigned IOCTL_DW  = 16;
    localparam int unsigned ROM_INDEX = 0;

endpackage

// File: rtl/ioctl_rom_loader.sv
// Splits 16-bit hps_io download words into little-endian ROM byte writes with backpressure.
// Optional additive byte checksum enabled by defining LOADER_CHECKSUM_EN.
module ioctl_rom_loader
    import mrlaggy_pkg::*;
#(
    parameter int unsigned AW    = 14,
    parameter int unsigned INDEX = ROM_INDEX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [15:0]         ioctl_index,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [IOCTL_DW-1:0] ioctl_dout,
    output logic                ioctl_wait,
    output logic [AW-1:0]       mem_addr,
    output logic [7:0]          mem_data,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic                busy,
    output logic                done,
    output logic [IOCTL_AW-1:0] size,
    output logic                err,
    output logic [15:0]         checksum
);

    state_t              state_q, state_d;
    logic [IOCTL_AW-1:0] addr_q, addr_d;
    logic [IOCTL_DW-1:0] dout_q, dout_d;
    logic                oor_q, oor_d;
    logic                pending_q, pending_d;
    logic                match_q;

    logic                wait_d, mem_we_d, busy_d, done_d, err_d;
    logic [AW-1:0]       mem_addr_d;
    logic [7:0]          mem_data_d;
    logic [IOCTL_AW-1:0] size_d;

    logic                idx_ok, match, start, fall, accept, byte_ack;
    logic [IOCTL_AW-1:0] end_addr;
    logic                unused_index;

    assign idx_ok   = (ioctl_index[5:0] == 6'(INDEX));
    assign match    = ioctl_download & idx_ok;
    assign start    = match & ~match_q;
    assign fall     = match_q & ~match;
    // A strobe coinciding with the download fall still belongs to this load.
    assign accept   = (state_q == IDLE) & ioctl_wr & (match | (match_q & idx_ok));
    assign byte_ack = mem_ready | oor_q;
    assign end_addr = addr_q + IOCTL_AW'(2);
    assign unused_index = ^ioctl_index[15:6];

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        oor_d      = oor_q;
        pending_d  = pending_q;
        wait_d     = ioctl_wait;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        size_d     = size;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;

        if (start) begin
            size_d = '0;
            err_d  = 1'b0;
            busy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = ioctl_addr;
                    dout_d  = ioctl_dout;
                    oor_d   = (ioctl_addr >> AW) != '0;
                    wait_d  = 1'b1;
                    state_d = LO;
                    if (oor_d) err_d = 1'b1;
                end
            end
            LO: begin
                if (ioctl_wr & match) err_d = 1'b1;
                if (byte_ack) state_d = HI;
            end
            HI: begin
                if (ioctl_wr & match) err_d = 1'b1;
                if (byte_ack) begin
                    state_d = IDLE;
                    wait_d  = 1'b0;
                    if (!oor_q && (end_addr > size_d)) size_d = end_addr;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion waits until the FSM is idle again so in-flight bytes are never cut off.
        if (state_q == IDLE) begin
            if ((fall && !accept) || pending_q) begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                pending_d = 1'b0;
            end else if (fall) begin
                pending_d = 1'b1;
            end
        end else if (fall) begin
            pending_d = 1'b1;
        end

        case (state_d)
            LO: begin
                mem_we_d   = ~oor_d;
                mem_addr_d = addr_d[AW-1:0];
                mem_data_d = dout_d[7:0];
            end
            HI: begin
                mem_we_d   = ~oor_d;
                mem_addr_d = addr_d[AW-1:0] + AW'(1);
                mem_data_d = dout_d[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            dout_q     <= '0;
            oor_q      <= 1'b0;
            pending_q  <= 1'b0;
            match_q    <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            size       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            oor_q      <= oor_d;
            pending_q  <= pending_d;
            match_q    <= match;
            ioctl_wait <= wait_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_data   <= mem_data_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            size       <= size_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum_d;

    // Sum of every byte the ROM actually accepted in this load.
    always_comb begin
        checksum_d = start ? 16'd0 : checksum;
        if (mem_we & mem_ready) checksum_d = checksum_d + 16'(mem_data);
    end

    always_ff @(posedge clk) begin
        if (reset) checksum <= '0;
        else       checksum <= checksum_d;
    end
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed test of ioctl_rom_loader: byte splitting, backpressure, filtering, range and abort handling.
module tb_ioctl_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        mem_ready;

    logic        ioctl_wait, mem_we, busy, done, err;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic [26:0] size;
    logic [15:0] checksum;

    logic        s_wait, s_mem_we, s_busy, s_done, s_err;
    logic [3:0]  s_mem_addr;
    logic [7:0]  s_mem_data;
    logic [26:0] s_size;
    logic [15:0] s_checksum;

    int checks = 0;
    int passed = 0;

    logic [13:0] cap_addr[$];
    logic [7:0]  cap_data[$];
    int done_cnt = 0;
    int s_we_cnt = 0;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [15:0] EXP_CKS = 16'h0264;
`else
    localparam logic [15:0] EXP_CKS = 16'h0000;
`endif

    ioctl_rom_loader #(.AW(14), .INDEX(0)) dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy), .done(done), .size(size), .err(err),
        .checksum(checksum)
    );

    ioctl_rom_loader #(.AW(4), .INDEX(0)) dut_s (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(s_wait), .mem_addr(s_mem_addr), .mem_data(s_mem_data), .mem_we(s_mem_we),
        .mem_ready(mem_ready), .busy(s_busy), .done(s_done), .size(s_size), .err(s_err),
        .checksum(s_checksum)
    );

    always #5 clk = ~clk;

    // Record every byte the ROM port accepts and every done pulse.
    always @(posedge clk) begin
        if (mem_we && mem_ready) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_data);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (s_mem_we) s_we_cnt <= s_we_cnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [26:0] a, input logic [15:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step;
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        int k;
        k = 0;
        while (ioctl_wait && k < 50) begin
            step;
            k++;
        end
        n = k;
        checks++;
        if (ioctl_wait) $display("FAIL wait_timeout: ioctl_wait=%b after %0d cycles, required 0", ioctl_wait, k);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) step;
        checks++; if (ioctl_wait !== 1'b0) $display("FAIL reset_wait: got %b exp 0", ioctl_wait); else passed++;
        checks++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b exp 0", mem_we); else passed++;
        checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {busy, done, err}); else passed++;
        checks++; if (size !== 27'd0) $display("FAIL reset_size: got %0d exp 0", size); else passed++;
        checks++; if (checksum !== 16'd0) $display("FAIL reset_cks: got %h exp 0000", checksum); else passed++;
        reset = 1'b0;
        step;
    endtask

    task automatic test_basic;
        int q0, d0, n;
        logic [15:0] words[4];
        logic [7:0]  eb;
        words[0] = 16'h2211; words[1] = 16'h4433; words[2] = 16'h6655; words[3] = 16'h8877;
        q0 = cap_data.size();
        d0 = done_cnt;
        mem_ready = 1'b1;
        ioctl_download = 1'b1;
        step;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b exp 1", busy); else passed++;
        for (int i = 0; i < 4; i++) begin
            send_word(27'(2 * i), words[i]);
            if (i == 0) begin
                checks++; if (ioctl_wait !== 1'b1) $display("FAIL basic_wait_hi: got %b exp 1", ioctl_wait); else passed++;
            end
            wait_idle(n);
            if (i == 0) begin
                checks++; if (n + 1 != 3) $display("FAIL basic_latency: got %0d exp 3", n + 1); else passed++;
            end
        end
        ioctl_download = 1'b0;
        step;
        checks++; if (done !== 1'b1) $display("FAIL basic_done: got %b exp 1", done); else passed++;
        step;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_clr: got %b exp 0", busy); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_cnt: got %0d exp 1", done_cnt - d0); else passed++;
        checks++; if (cap_data.size() - q0 != 8) $display("FAIL basic_nbytes: got %0d exp 8", cap_data.size() - q0); else passed++;
        for (int i = 0; i < 8 && q0 + i < cap_data.size(); i++) begin
            eb = 8'(8'h11 * (i + 1));
            checks++;
            if (cap_addr[q0 + i] !== 14'(i) || cap_data[q0 + i] !== eb)
                $display("FAIL basic_byte%0d: got %h@%0d exp %h@%0d", i, cap_data[q0 + i], cap_addr[q0 + i], eb, i);
            else passed++;
        end
        checks++; if (size !== 27'd8) $display("FAIL basic_size: got %0d exp 8", size); else passed++;
        checks++; if (checksum !== EXP_CKS) $display("FAIL basic_cks: got %h exp %h", checksum, EXP_CKS); else passed++;
    endtask

    task automatic test_backpressure;
        int q0, n;
        logic stable;
        q0 = cap_data.size();
        mem_ready = 1'b0;
        ioctl_download = 1'b1;
        step;
        send_word(27'd8, 16'hBBAA);
        stable = 1'b1;
        repeat (5) begin
            step;
            if (!(ioctl_wait === 1'b1 && mem_we === 1'b1 && mem_addr === 14'd8 && mem_data === 8'hAA)) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b exp 1", stable); else passed++;
        send_word(27'd10, 16'hFFEE);
        checks++; if (err !== 1'b1) $display("FAIL bp_err_busy_wr: got %b exp 1", err); else passed++;
        checks++; if (mem_data !== 8'hAA) $display("FAIL bp_data_kept: got %h exp aa", mem_data); else passed++;
        mem_ready = 1'b1;
        wait_idle(n);
        ioctl_download = 1'b0;
        step;
        step;
        checks++;
        if (cap_data.size() - q0 != 2 || cap_addr[q0] !== 14'd8 || cap_data[q0] !== 8'hAA ||
            cap_addr[q0 + 1] !== 14'd9 || cap_data[q0 + 1] !== 8'hBB)
            $display("FAIL bp_bytes: got %0d bytes, first %h, exp 2 bytes aa@8 bb@9", cap_data.size() - q0, cap_data[q0]);
        else passed++;
        checks++; if (size !== 27'd10) $display("FAIL bp_size: got %0d exp 10", size); else passed++;
    endtask

    task automatic test_index_filter;
        int q0, d0;
        q0 = cap_data.size();
        d0 = done_cnt;
        ioctl_index = 16'd1;
        ioctl_download = 1'b1;
        step;
        send_word(27'd0, 16'h1234);
        checks++; if (ioctl_wait !== 1'b0 || busy !== 1'b0) $display("FAIL idx_wait_busy: got %b%b exp 00", ioctl_wait, busy); else passed++;
        step;
        ioctl_download = 1'b0;
        step;
        step;
        checks++; if (cap_data.size() != q0) $display("FAIL idx_no_we: got %0d bytes exp 0", cap_data.size() - q0); else passed++;
        checks++; if (done_cnt != d0) $display("FAIL idx_no_done: got %0d exp 0", done_cnt - d0); else passed++;
        checks++; if (size !== 27'd10) $display("FAIL idx_size: got %0d exp 10", size); else passed++;
        ioctl_index = 16'd0;
    endtask

    task automatic test_out_of_range;
        int w0, k;
        w0 = s_we_cnt;
        mem_ready = 1'b1;
        ioctl_download = 1'b1;
        step;
        send_word(27'd16, 16'h5566);
        checks++; if (s_wait !== 1'b1) $display("FAIL oor_wait: got %b exp 1", s_wait); else passed++;
        k = 0;
        while (s_wait && k < 50) begin
            step;
            k++;
        end
        checks++; if (s_wait !== 1'b0) $display("FAIL oor_wait_timeout: got %b exp 0", s_wait); else passed++;
        checks++; if (s_we_cnt != w0) $display("FAIL oor_no_we: got %0d exp 0", s_we_cnt - w0); else passed++;
        checks++; if (s_err !== 1'b1) $display("FAIL oor_err: got %b exp 1", s_err); else passed++;
        checks++; if (s_size !== 27'd0) $display("FAIL oor_size: got %0d exp 0", s_size); else passed++;
        ioctl_download = 1'b0;
        step;
        step;
    endtask

    task automatic test_fall_in_lo;
        int q0, d0;
        q0 = cap_data.size();
        d0 = done_cnt;
        mem_ready = 1'b0;
        ioctl_download = 1'b1;
        step;
        send_word(27'd0, 16'hDDCC);
        ioctl_download = 1'b0;
        repeat (3) step;
        checks++; if (done_cnt != d0 || busy !== 1'b1) $display("FAIL fall_early: done %0d busy %b exp 0 1", done_cnt - d0, busy); else passed++;
        mem_ready = 1'b1;
        repeat (6) step;
        checks++; if (done_cnt - d0 != 1) $display("FAIL fall_done_once: got %0d exp 1", done_cnt - d0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL fall_busy: got %b exp 0", busy); else passed++;
        checks++;
        if (cap_data.size() - q0 != 2 || cap_data[q0] !== 8'hCC || cap_data[q0 + 1] !== 8'hDD)
            $display("FAIL fall_bytes: got %0d bytes exp cc dd", cap_data.size() - q0);
        else passed++;
    endtask

    task automatic test_reset_in_hi;
        int q0, d0, n;
        d0 = done_cnt;
        mem_ready = 1'b0;
        ioctl_download = 1'b1;
        step;
        send_word(27'd4, 16'h4433);
        mem_ready = 1'b1;
        step;
        mem_ready = 1'b0;
        checks++; if (mem_addr !== 14'd5 || mem_data !== 8'h44) $display("FAIL rst_in_hi: got %h@%0d exp 44@5", mem_data, mem_addr); else passed++;
        reset = 1'b1;
        step;
        checks++;
        if ({ioctl_wait, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 14'd0 || mem_data !== 8'd0 ||
            size !== 27'd0 || checksum !== 16'd0)
            $display("FAIL rst_hi_outputs: wait %b we %b busy %b size %0d exp all 0", ioctl_wait, mem_we, busy, size);
        else passed++;
        reset = 1'b0;
        step;
        checks++; if (done_cnt != d0) $display("FAIL rst_no_done: got %0d exp 0", done_cnt - d0); else passed++;
        q0 = cap_data.size();
        mem_ready = 1'b1;
        send_word(27'd0, 16'h2211);
        wait_idle(n);
        ioctl_download = 1'b0;
        step;
        step;
        checks++; if (done_cnt - d0 != 1) $display("FAIL rst_fresh_done: got %0d exp 1", done_cnt - d0); else passed++;
        checks++; if (size !== 27'd2) $display("FAIL rst_fresh_size: got %0d exp 2", size); else passed++;
        checks++;
        if (cap_data.size() - q0 != 2 || cap_data[q0] !== 8'h11 || cap_data[q0 + 1] !== 8'h22)
            $display("FAIL rst_fresh_bytes: got %0d bytes exp 11 22", cap_data.size() - q0);
        else passed++;
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 16'd0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ready      = 1'b1;
        test_reset;
        test_basic;
        test_backpressure;
        test_index_filter;
        test_out_of_range;
        test_fall_in_lo;
        test_reset_in_hi;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
